// File: rtl/s_cska_sub_seq_if.sv
// Operand/result handshake bundle for the sequential carry-skip subtractor.
// The master side is the producer/consumer; the slave side is the subtractor.
interface s_cska_sub_seq_if #(
    parameter int N     = 8,
    parameter int BLOCK = 4
);
    localparam int SW = $clog2(N / BLOCK + 1);

    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic [N:0]    s_cska_sub_seq_out;
    logic [SW-1:0] skip_cnt;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, s_cska_sub_seq_out, skip_cnt
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, s_cska_sub_seq_out, skip_cnt
    );
endinterface

// File: rtl/s_cska_sub_seq.sv
// Multi-cycle signed subtractor: a + ~b + 1 evaluated one carry-skip group
// per clock, producing the exact sign-extended (N+1)-bit difference.
module s_cska_sub_seq #(
    parameter int N     = 8,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    s_cska_sub_seq_if.slave  bus
);
    localparam int NB = N / BLOCK;
    localparam int SW = $clog2(NB + 1);
    localparam int GW = (NB > 1) ? $clog2(NB) : 1;
    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q;
    logic [N-1:0]    a_q;
    logic [N-1:0]    nb_q;
    logic            carry_q;
    logic [GW-1:0]   grp_q;
    logic [SW-1:0]   skip_q;
    logic [N:0]      res_q;
    logic            in_ready_q;
    logic            out_valid_q;

    logic [IW-1:0]    base;
    logic [BLOCK-1:0] ga, gb, p, g, sum_d;
    logic             c, carry_d, all_p;

    // Ripple through the current group; the skip mux bypasses the ripple
    // whenever every bit of the group propagates.
    always_comb begin
        base  = IW'(int'(grp_q) * BLOCK);
        ga    = a_q[base +: BLOCK];
        gb    = nb_q[base +: BLOCK];
        p     = ga ^ gb;
        g     = ga & gb;
        c     = carry_q;
        sum_d = '0;
        for (int unsigned i = 0; i < BLOCK; i++) begin
            sum_d[i] = p[i] ^ c;
            c        = g[i] | (p[i] & c);
        end
        all_p   = &p;
        carry_d = all_p ? carry_q : c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            nb_q        <= '0;
            carry_q     <= 1'b1;
            grp_q       <= '0;
            skip_q      <= '0;
            res_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.a;
                        nb_q       <= ~bus.b;
                        carry_q    <= 1'b1;
                        grp_q      <= '0;
                        skip_q     <= '0;
                        res_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    res_q[base +: BLOCK] <= sum_d;
                    carry_q              <= carry_d;
                    if (all_p) begin
                        skip_q <= skip_q + SW'(1);
                    end
                    if (grp_q == GW'(NB - 1)) begin
                        res_q[N]    <= a_q[N-1] ^ nb_q[N-1] ^ carry_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        grp_q <= grp_q + GW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready           = in_ready_q;
    assign bus.out_valid          = out_valid_q;
    assign bus.s_cska_sub_seq_out = res_q;
    assign bus.skip_cnt           = skip_q;
endmodule

// File: tb/tb_s_cska_sub_seq.sv
// Bench for s_cska_sub_seq: directed corner cases, reset abort, long stall
// and random operands compared with a plain-arithmetic reference.
module tb_s_cska_sub_seq;
    localparam int N     = 8;
    localparam int BLOCK = 4;
    localparam int NB    = N / BLOCK;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    s_cska_sub_seq_if #(.N(N), .BLOCK(BLOCK)) bus ();

    s_cska_sub_seq #(.N(N), .BLOCK(BLOCK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference: exact difference of sign-extended operands.
    function automatic logic [N:0] ref_diff(input logic [N-1:0] av, input logic [N-1:0] bv);
        return {av[N-1], av} - {bv[N-1], bv};
    endfunction

    // A group skips exactly when a and b agree on all of its bits.
    function automatic int ref_skip(input logic [N-1:0] av, input logic [N-1:0] bv);
        int cnt = 0;
        logic [N-1:0] mask = N'((1 << BLOCK) - 1);
        for (int k = 0; k < NB; k++) begin
            if ((((av ^ bv) >> (k * BLOCK)) & mask) == '0) cnt++;
        end
        return cnt;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [N-1:0] av, input logic [N-1:0] bv,
                          input int hold, input bit iv_at_hs, input string tag);
        logic [N:0] e;
        int         es;
        int         cyc;
        e   = ref_diff(av, bv);
        es  = ref_skip(av, bv);
        cyc = 0;
        while (!bus.in_ready && cyc < 50) begin
            tick();
            cyc++;
        end
        chk({tag, "_ready_wait"}, 32'(cyc < 50), 32'd1);
        bus.in_valid = 1'b1;
        bus.a        = av;
        bus.b        = bv;
        tick();
        bus.in_valid = 1'b0;
        bus.a        = N'($urandom);
        bus.b        = N'($urandom);
        chk({tag, "_inrdy_busy"}, 32'(bus.in_ready), 32'd0);
        cyc = 0;
        while (!bus.out_valid && cyc < 50) begin
            tick();
            cyc++;
        end
        chk({tag, "_latency"}, 32'(cyc), 32'(NB));
        chk({tag, "_result"}, 32'(bus.s_cska_sub_seq_out), 32'(e));
        chk({tag, "_skip"}, 32'(bus.skip_cnt), 32'(es));
        bus.out_ready = 1'b0;
        for (int k = 0; k < hold; k++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.a        = N'($urandom);
            tick();
            chk({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
            chk({tag, "_hold_result"}, 32'(bus.s_cska_sub_seq_out), 32'(e));
            chk({tag, "_hold_inrdy"}, 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = iv_at_hs;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk({tag, "_drain_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_drain_inrdy"}, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_inrdy"}, 32'(bus.in_ready), 32'd1);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_out"}, 32'(bus.s_cska_sub_seq_out), 32'd0);
        chk({tag, "_skip"}, 32'(bus.skip_cnt), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        rst           = 1'b1;
        tick();
        tick();
        chk_reset_state("reset");
        rst = 1'b0;
        tick();

        // Directed corners; spot-check the model against known constants too.
        chk("model_7f_80", 32'(ref_diff(8'h7F, 8'h80)), 32'h0FF);
        chk("model_80_7f", 32'(ref_diff(8'h80, 8'h7F)), 32'h101);
        run_op(8'h7F, 8'h80, 0, 1'b0, "max_pos");
        run_op(8'h80, 8'h7F, 0, 1'b0, "max_neg");
        run_op(8'h00, 8'h00, 0, 1'b0, "zero");
        run_op(8'h05, 8'h05, 0, 1'b0, "equal_skip");
        run_op(8'h10, 8'h01, 0, 1'b0, "no_skip");
        run_op(8'hFF, 8'h01, 1, 1'b1, "neg_one");

        // Long stall in DONE with in_valid noise, handshake coinciding with in_valid.
        run_op(8'h3C, 8'hA5, 10, 1'b1, "stall");

        // Abort on first RUN cycle.
        bus.in_valid = 1'b1;
        bus.a        = 8'h55;
        bus.b        = 8'h12;
        tick();
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_state("rst_run");
        run_op(8'h55, 8'h12, 0, 1'b0, "after_rst_run");

        // Abort while holding a result in DONE.
        bus.in_valid = 1'b1;
        bus.a        = 8'h81;
        bus.b        = 8'h7E;
        tick();
        bus.in_valid = 1'b0;
        cyc = 0;
        while (!bus.out_valid && cyc < 50) begin
            tick();
            cyc++;
        end
        chk("rst_done_reach", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_state("rst_done");
        run_op(8'hC0, 8'h40, 0, 1'b0, "after_rst_done");

        // Random operands with random idle gaps and consumer stalls.
        for (int t = 0; t < 1000; t++) begin
            logic [N-1:0] ra;
            logic [N-1:0] rb;
            int           gap;
            ra  = N'($urandom);
            rb  = ($urandom_range(0, 7) == 0) ? ra : N'($urandom);
            gap = $urandom_range(0, 2);
            for (int k = 0; k < gap; k++) tick();
            run_op(ra, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
